// File: rtl/fp16_pack.sv
// FP16 encoder: category code plus payload in, legal half-precision pattern out.
// Two-stage valid/ready pipeline with legalization flags and a saturating error counter.
module fp16_pack #(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_class,
    input  logic               in_sign,
    input  logic [4:0]         in_exp,
    input  logic [9:0]         in_mant,
    input  logic               cnt_clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [15:0]        out,
    output logic               out_fixup,
    output logic               out_bad_class,
    output logic [COUNT_W-1:0] err_count
);

    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    logic       d_sign;
    logic [4:0] d_exp;
    logic [9:0] d_mant;
    logic       d_fixup;
    logic       d_bad;

    logic       s1_valid;
    logic       s1_sign;
    logic [4:0] s1_exp;
    logic [9:0] s1_mant;
    logic       s1_fixup;
    logic       s1_bad;

    logic       s2_advance;
    logic       out_xfer;

    // Decode category and payload into legal output fields.
    always_comb begin
        d_sign  = 1'b0;
        d_exp   = 5'h00;
        d_mant  = 10'h000;
        d_fixup = 1'b0;
        d_bad   = 1'b0;
        case (in_class)
            4'd0: begin
                d_sign  = in_sign;
                d_exp   = 5'h1F;
                d_mant  = {1'b0, in_mant[8:0]};
                d_fixup = in_mant[9];
                if (in_mant[8:0] == 9'd0) begin
                    d_mant  = 10'h001;
                    d_fixup = 1'b1;
                end
            end
            4'd1: begin
                d_sign  = in_sign;
                d_exp   = 5'h1F;
                d_mant  = {1'b1, in_mant[8:0]};
                d_fixup = ~in_mant[9];
            end
            4'd2, 4'd9: begin
                d_sign = (in_class == 4'd2);
                d_exp  = 5'h1F;
            end
            4'd3, 4'd8: begin
                d_sign = (in_class == 4'd3);
                d_exp  = in_exp;
                d_mant = in_mant;
                if (in_exp == 5'h00) begin
                    d_exp   = 5'h01;
                    d_fixup = 1'b1;
                end else if (in_exp == 5'h1F) begin
                    d_exp   = 5'h1E;
                    d_fixup = 1'b1;
                end
            end
            4'd4, 4'd7: begin
                d_sign = (in_class == 4'd4);
                d_mant = in_mant;
                if (in_mant == 10'h000) begin
                    d_mant  = 10'h001;
                    d_fixup = 1'b1;
                end
            end
            4'd5, 4'd6: begin
                d_sign = (in_class == 4'd5);
            end
            default: begin
                // Canonical quiet NaN for unknown categories.
                d_exp  = 5'h1F;
                d_mant = 10'h200;
                d_bad  = 1'b1;
            end
        endcase
    end

    assign s2_advance = ~out_valid | out_ready;
    assign in_ready   = ~s1_valid | s2_advance;
    assign out_xfer   = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_exp   <= 5'h00;
            s1_mant  <= 10'h000;
            s1_fixup <= 1'b0;
            s1_bad   <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign  <= d_sign;
                s1_exp   <= d_exp;
                s1_mant  <= d_mant;
                s1_fixup <= d_fixup;
                s1_bad   <= d_bad;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out           <= 16'h0000;
            out_fixup     <= 1'b0;
            out_bad_class <= 1'b0;
        end else if (s2_advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out           <= {s1_sign, s1_exp, s1_mant};
                out_fixup     <= s1_fixup;
                out_bad_class <= s1_bad;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (cnt_clr) begin
            err_count <= '0;
        end else if (out_xfer && (out_fixup || out_bad_class) && (err_count != CNT_MAX)) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_fp16_pack.sv
// Directed bench for fp16_pack: vector table, latency, backpressure and counter saturation.
// A second instance with a 2-bit counter shares the stimulus for the saturation checks.
module tb_fp16_pack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_class;
    logic        in_sign;
    logic [4:0]  in_exp;
    logic [9:0]  in_mant;
    logic        cnt_clr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic        out_fixup;
    logic        out_bad_class;
    logic [7:0]  err_count;

    logic        sat_in_ready;
    logic        sat_out_valid;
    logic [15:0] sat_out;
    logic        sat_fixup;
    logic        sat_bad;
    logic [1:0]  sat_err;

    always #5 clk = ~clk;

    fp16_pack dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .cnt_clr(cnt_clr), .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .out_fixup(out_fixup), .out_bad_class(out_bad_class), .err_count(err_count)
    );

    fp16_pack #(.COUNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(sat_in_ready),
        .in_class(in_class), .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .cnt_clr(cnt_clr), .out_valid(sat_out_valid), .out_ready(out_ready), .out(sat_out),
        .out_fixup(sat_fixup), .out_bad_class(sat_bad), .err_count(sat_err)
    );

    typedef struct {
        logic [3:0]  cls;
        logic        sgn;
        logic [4:0]  ex;
        logic [9:0]  mn;
        logic [15:0] word;
        logic        fix;
        logic        bad;
    } vec_t;

    typedef struct {
        logic [15:0] word;
        logic        fix;
        logic        bad;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   rx_count = 0;
    logic        held = 1'b0;
    logic [17:0] held_val;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Scoreboard: every output transfer must match the next expected beat in order.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            rx_count++;
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_beat: got %04h expected no beat", out);
            end else begin
                mon_e = expq.pop_front();
                chk("out_word", {16'h0, out}, {16'h0, mon_e.word});
                chk("out_fixup", {31'h0, out_fixup}, {31'h0, mon_e.fix});
                chk("out_bad_class", {31'h0, out_bad_class}, {31'h0, mon_e.bad});
            end
        end
        if (rst_n && out_valid && !out_ready) begin
            if (held) chk("stall_hold", {14'h0, out, out_fixup, out_bad_class}, {14'h0, held_val});
            held     = 1'b1;
            held_val = {out, out_fixup, out_bad_class};
        end else begin
            held = 1'b0;
        end
    end

    task automatic send(input logic [3:0] c, input logic s, input logic [4:0] e,
                        input logic [9:0] m, input logic [15:0] w, input logic f,
                        input logic b);
        logic ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_class = c;
        in_sign  = s;
        in_exp   = e;
        in_mant  = m;
        repeat (100) begin
            if (!ok) begin
                @(negedge clk);
                ok = in_ready;
            end
        end
        if (ok) begin
            expq.push_back('{w, f, b});
        end else begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        logic ok;
        ok = 1'b0;
        repeat (200) begin
            if (!ok) begin
                @(negedge clk);
                ok = (expq.size() == 0) && !out_valid;
            end
        end
        chk("drain_done", {31'h0, ok}, 32'h1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs[14];

    initial begin
        logic ok;
        vecs[0]  = '{4'd0,  1'b1, 5'h00, 10'h000, 16'hFC01, 1'b1, 1'b0};
        vecs[1]  = '{4'd1,  1'b1, 5'h00, 10'h000, 16'hFE00, 1'b1, 1'b0};
        vecs[2]  = '{4'd2,  1'b1, 5'h00, 10'h000, 16'hFC00, 1'b0, 1'b0};
        vecs[3]  = '{4'd3,  1'b1, 5'h00, 10'h000, 16'h8400, 1'b1, 1'b0};
        vecs[4]  = '{4'd4,  1'b1, 5'h00, 10'h000, 16'h8001, 1'b1, 1'b0};
        vecs[5]  = '{4'd5,  1'b1, 5'h00, 10'h000, 16'h8000, 1'b0, 1'b0};
        vecs[6]  = '{4'd6,  1'b1, 5'h00, 10'h000, 16'h0000, 1'b0, 1'b0};
        vecs[7]  = '{4'd7,  1'b1, 5'h00, 10'h000, 16'h0001, 1'b1, 1'b0};
        vecs[8]  = '{4'd8,  1'b1, 5'h00, 10'h000, 16'h0400, 1'b1, 1'b0};
        vecs[9]  = '{4'd9,  1'b1, 5'h00, 10'h000, 16'h7C00, 1'b0, 1'b0};
        vecs[10] = '{4'd8,  1'b0, 5'h1F, 10'h3FF, 16'h7BFF, 1'b1, 1'b0};
        vecs[11] = '{4'd1,  1'b0, 5'h00, 10'h155, 16'h7F55, 1'b1, 1'b0};
        vecs[12] = '{4'd0,  1'b0, 5'h00, 10'h200, 16'h7C01, 1'b1, 1'b0};
        vecs[13] = '{4'd12, 1'b0, 5'h00, 10'h000, 16'h7E00, 1'b0, 1'b1};

        // Reset held with a beat offered.
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_class  = 4'd8;
        in_sign   = 1'b0;
        in_exp    = 5'h0F;
        in_mant   = 10'h000;
        cnt_clr   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
        chk("reset_err_count", {24'h0, err_count}, 32'h0);
        chk("reset_in_ready", {31'h0, in_ready}, 32'h1);
        chk("reset_out", {16'h0, out}, 32'h0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;

        // Two-cycle latency.
        in_valid = 1'b1;
        in_class = 4'd8;
        in_exp   = 5'h0F;
        in_mant  = 10'h000;
        chk("lat_in_ready", {31'h0, in_ready}, 32'h1);
        expq.push_back('{16'h3C00, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("lat_cycle1_valid", {31'h0, out_valid}, 32'h0);
        @(posedge clk);
        #1;
        chk("lat_cycle2_valid", {31'h0, out_valid}, 32'h1);
        chk("lat_out", {16'h0, out}, 32'h3C00);
        chk("lat_fixup", {31'h0, out_fixup}, 32'h0);
        drain();

        // Vector table: class sweep, legalization, illegal class.
        for (int i = 0; i < 14; i++) begin
            send(vecs[i].cls, vecs[i].sgn, vecs[i].ex, vecs[i].mn,
                 vecs[i].word, vecs[i].fix, vecs[i].bad);
            if (i == 9) begin
                drain();
                chk("err_after_sweep", {24'h0, err_count}, 32'd6);
            end else if (i == 12) begin
                drain();
                chk("err_after_legal", {24'h0, err_count}, 32'd9);
            end
        end
        drain();
        chk("err_after_illegal", {24'h0, err_count}, 32'd10);

        // Backpressure: two beats fill the pipe, then in_ready must drop.
        out_ready = 1'b0;
        send(4'd7, 1'b0, 5'h00, 10'd1, 16'h0001, 1'b0, 1'b0);
        send(4'd7, 1'b0, 5'h00, 10'd2, 16'h0002, 1'b0, 1'b0);
        chk("bp_in_ready_full", {31'h0, in_ready}, 32'h0);
        chk("bp_out_valid_full", {31'h0, out_valid}, 32'h1);
        rx_count = 0;
        fork
            begin
                for (int k = 3; k <= 8; k++)
                    send(4'd7, 1'b0, 5'h00, 10'(k), 16'(k), 1'b0, 1'b0);
            end
            begin
                for (int i = 0; i < 30; i++) begin
                    out_ready = (i < 5 || (i >= 12 && i < 17)) ? 1'b0 : 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_beat_count", rx_count, 32'd8);
        chk("bp_err_unchanged", {24'h0, err_count}, 32'd10);

        // Saturation on the 2-bit instance, then clear racing an error transfer.
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        chk("clr_err", {24'h0, err_count}, 32'h0);
        chk("clr_sat_err", {30'h0, sat_err}, 32'h0);
        for (int i = 10; i < 15; i++)
            send(4'(i), 1'b0, 5'h00, 10'h000, 16'h7E00, 1'b0, 1'b1);
        drain();
        chk("sat_err_saturated", {30'h0, sat_err}, 32'd3);
        chk("sat_err_wide", {24'h0, err_count}, 32'd5);

        out_ready = 1'b0;
        send(4'd15, 1'b0, 5'h00, 10'h000, 16'h7E00, 1'b0, 1'b1);
        ok = 1'b0;
        repeat (10) begin
            if (!ok) begin
                @(posedge clk);
                #1;
                ok = out_valid;
            end
        end
        chk("clr_race_out_valid", {31'h0, ok}, 32'h1);
        out_ready = 1'b1;
        cnt_clr   = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        chk("clr_race_err", {24'h0, err_count}, 32'h0);
        chk("clr_race_sat_err", {30'h0, sat_err}, 32'h0);
        drain();
        chk("clr_race_err_after", {24'h0, err_count}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp16_pack.md
Name: fp16_pack

Overview:
- Pipelined FP16 encoder: the inverse of the team's FP16 classifier.
- Takes a category code plus sign/exponent/mantissa payload and emits a legal IEEE 754 half-precision bit pattern for that category. Illegal payloads are legalized and flagged.
- Sits in front of FP16 datapaths and test-vector generators that must produce guaranteed-category operands.
- Valid/ready on both sides; 2-stage pipeline; saturating error counter.

Parameters:
- COUNT_W, 8, width of the saturating legalization/error counter.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts the input beat this cycle.
- in_class  input  4  category code: 0 snan, 1 qnan, 2 neg_inf, 3 neg_normal, 4 neg_denormal, 5 neg_zero, 6 pos_zero, 7 pos_denormal, 8 pos_normal, 9 pos_inf, 10-15 illegal.
- in_sign  input  1  sign bit, used for NaN classes only.
- in_exp  input  5  biased exponent payload, used for normal classes only.
- in_mant  input  10  mantissa payload.
- cnt_clr  input  1  synchronous clear of err_count.
- out_valid  output  1  output beat present.
- out_ready  input  1  downstream accepts the output beat.
- out  output  16  encoded FP16 value.
- out_fixup  output  1  payload was legalized for this beat.
- out_bad_class  output  1  in_class was illegal (10-15).
- err_count  output  COUNT_W  number of accepted output beats with out_fixup or out_bad_class set.

Behaviour:
- Reset (rst_n low, asynchronous): both stage valids = 0; out, out_fixup, out_bad_class = 0; err_count = 0. In the empty state in_ready = 1.
- Handshake:
  - Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
  - out, out_fixup and out_bad_class hold stable while out_valid && !out_ready.
  - in_ready = !s1_valid || (!s2_valid || out_ready). This is combinational from state and out_ready, never from in_valid.
- Pipeline:
  - Stage 1 registers the decoded fields.
  - Stage 2 registers the packed word and flags, which drive the outputs.
  - Latency is 2 cycles from input transfer to out_valid with out_ready held high.
  - Throughput is 1 beat/cycle. No beat is dropped or duplicated under any out_ready pattern.
  - Order is preserved.
- Encoding rules, with {sign, exp, mant} written as the output fields:
  - snan: {in_sign, 5'h1F, {1'b0, in_mant[8:0]}}. If in_mant[8:0] == 0, mant = 10'h001. fixup = 1 if in_mant[9] == 1 or in_mant[8:0] == 0.
  - qnan: {in_sign, 5'h1F, {1'b1, in_mant[8:0]}}. fixup = 1 if in_mant[9] == 0.
  - neg/pos_inf: {s, 5'h1F, 0}, with s = 1 for neg and 0 for pos. Payload ignored; fixup = 0.
  - neg/pos_zero: {s, 0, 0}. Payload ignored; fixup = 0.
  - neg/pos_denormal: {s, 0, in_mant}. If in_mant == 0, mant = 10'h001 and fixup = 1.
  - neg/pos_normal: {s, in_exp, in_mant}.
    - in_exp == 0 → exp = 5'h01, fixup = 1.
    - in_exp == 5'h1F → exp = 5'h1E, fixup = 1.
  - Illegal class: out = 16'h7E00 (canonical qNaN), bad_class = 1, fixup = 0.
- err_count:
  - Increments by 1 on each output transfer with out_fixup || out_bad_class.
  - Saturates at 2^COUNT_W-1 (no wrap).
  - cnt_clr sets it to 0 on the next edge. Clear wins over a simultaneous increment.
- Reset mid-operation: all in-flight beats are discarded and no output transfer is reported. Behaviour afterwards is identical to post-reset.

Test Plan:
- Reset with in_valid = 1 → out_valid = 0, err_count = 0, in_ready = 1. After release, send pos_normal exp = 5'h0F, mant = 0, out_ready = 1 → out = 16'h3C00 exactly 2 cycles later, fixup = 0.
- Class sweep 0-9 back to back, payload exp = 0, mant = 0, sign = 1, out_ready = 1:
  - Expected outs: 0xFC01, 0xFE00, 0xFC00, 0x8400, 0x8001, 0x8000, 0x0000, 0x0001, 0x0400, 0x7C00.
  - Fixup pattern: 1, 1, 0, 1, 1, 0, 0, 1, 1, 0.
  - err_count = 6 at the end.
- Legalization:
  - pos_normal exp = 5'h1F, mant = 0x3FF → 0x7BFF, fixup = 1.
  - qnan sign = 0, mant = 0x155 → 0x7F55, fixup = 1.
  - snan mant = 0x200 → 0x7C01, fixup = 1.
- Illegal class 12 → out = 0x7E00, bad_class = 1, err_count increments by 1.
- Backpressure: stream 8 beats with out_ready toggled by a random pattern including 5-cycle stalls → in_ready falls after 2 beats are buffered. All 8 outputs arrive in order, unchanged while stalled, with no duplicates.
- COUNT_W = 2: 5 illegal beats → err_count saturates at 3. Assert cnt_clr on the same cycle as a 6th error transfer → err_count = 0.
